// File: rtl/rv_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_sb_pkg
//  Description : Shared constants and helpers for the register scoreboard.
//                Register-file class codes, the standard functional-unit
//                latencies used by decode, and a width helper that never
//                returns zero.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_sb_pkg;

  // Register-file classes
  localparam int RF_INT = 0;
  localparam int RF_FP  = 1;

  // Functional-unit result latencies (0 = released by a write-back port)
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_FADD = 3;
  localparam int LAT_FMUL = 4;
  localparam int LAT_VAR  = 0;

  // $clog2 clamped to at least one bit, so a single-class build still has
  // a legal class-select field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
//  Module      : sb_entry
//  Description : One scoreboard entry: a busy bit plus a result down-counter.
//                A non-zero count frees the entry by itself when it reaches
//                one; a zero count waits for a write-back clear.
//  Ports       : clk, reset      clock / synchronous active-high reset
//                flush           drop the pending result (beats set)
//                set, set_cnt    start tracking a new result with latency
//                wb_clr          variable-latency result has been written
//                busy, cnt       registered state
//                busy_nxt        next-cycle busy value (for population count)
//  Revision    : 1.0  initial release
// ============================================================================
module sb_entry #(
  parameter int LATW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            set,
  input  logic [LATW-1:0] set_cnt,
  input  logic            wb_clr,
  output logic            busy,
  output logic [LATW-1:0] cnt,
  output logic            busy_nxt
);

  logic            r_busy;
  logic [LATW-1:0] r_cnt;
  logic            w_busy_nxt;
  logic [LATW-1:0] w_cnt_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    if (flush) begin
      w_busy_nxt = 1'b0;
      w_cnt_nxt  = '0;
    end else if (set) begin
      w_busy_nxt = 1'b1;
      w_cnt_nxt  = set_cnt;
    end else if (r_busy) begin
      if (r_cnt > LATW'(1)) begin
        w_cnt_nxt = r_cnt - LATW'(1);
      end else if (r_cnt == LATW'(1)) begin
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end else if (wb_clr) begin
        // count of zero: only a write-back releases the entry
        w_busy_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign cnt      = r_cnt;
  assign busy_nxt = w_busy_nxt;

endmodule
`default_nettype wire

// File: rtl/rv_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rv_scoreboard
//  Description : Register scoreboard for the pipelined core. Tracks pending
//                results per (class, register), reports RAW/WAW hazards to
//                decode, flags sources that are available on the forwarding
//                network next cycle, and keeps a registered busy count.
//  Ports       : clk, reset                 clock / sync active-high reset
//                iss_*                      instruction presented by decode
//                iss_ready                  no hazard (independent of valid)
//                fwd_rs1, fwd_rs2           source comes from forwarding
//                wb_valid, wb_rd, wb_rf     variable-latency write-back ports
//                flush                      clear every pending entry
//                busy_count, idle           registered occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module rv_scoreboard
  import rv_sb_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NRF      = 2,
  parameter int MAXLAT   = 16,
  parameter int NWB      = 2,
  parameter int ZERO_RF0 = 1,
  localparam int ADDRW   = $clog2(NREG),
  localparam int RFW     = clog2_min1(NRF),
  localparam int LATW    = $clog2(MAXLAT + 1),
  localparam int CNTW    = $clog2(NRF * NREG + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [ADDRW-1:0]     iss_rs1,
  input  logic [ADDRW-1:0]     iss_rs2,
  input  logic [RFW-1:0]       iss_rs1_rf,
  input  logic [RFW-1:0]       iss_rs2_rf,
  input  logic                 iss_rs1_use,
  input  logic                 iss_rs2_use,
  input  logic [ADDRW-1:0]     iss_rd,
  input  logic [RFW-1:0]       iss_rd_rf,
  input  logic                 iss_rd_we,
  input  logic [LATW-1:0]      iss_lat,
  output logic                 iss_ready,
  output logic                 fwd_rs1,
  output logic                 fwd_rs2,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*ADDRW-1:0] wb_rd,
  input  logic [NWB*RFW-1:0]   wb_rf,
  input  logic                 flush,
  output logic [CNTW-1:0]      busy_count,
  output logic                 idle
);

  localparam int NENT = NRF * NREG;

  logic [NENT-1:0] w_busy;
  logic [NENT-1:0] w_busy_nxt;
  logic [NENT-1:0] w_cnt_is1;
  logic [NENT-1:0] w_sel_rs1;
  logic [NENT-1:0] w_sel_rs2;
  logic [NENT-1:0] w_sel_rd;

  logic w_rs1_zero, w_rs2_zero, w_rd_zero;
  logic w_rs1_busy, w_rs2_busy, w_rd_busy;
  logic w_rs1_last, w_rs2_last;
  logic w_raw1, w_raw2, w_waw;
  logic w_fire_wr;
  logic [CNTW-1:0] w_pop;
  logic [CNTW-1:0] r_busy_count;
  logic            r_idle;

  // Hard-wired zero register: never stalls, never forwards, never tracked.
  assign w_rs1_zero = (ZERO_RF0 != 0) && (iss_rs1_rf == RFW'(RF_INT)) && (iss_rs1 == '0);
  assign w_rs2_zero = (ZERO_RF0 != 0) && (iss_rs2_rf == RFW'(RF_INT)) && (iss_rs2 == '0);
  assign w_rd_zero  = (ZERO_RF0 != 0) && (iss_rd_rf  == RFW'(RF_INT)) && (iss_rd  == '0);

  // Hazard muxes are one-hot AND-OR reductions over the registered state.
  assign w_rs1_busy = |(w_busy & w_sel_rs1);
  assign w_rs2_busy = |(w_busy & w_sel_rs2);
  assign w_rd_busy  = |(w_busy & w_sel_rd);
  assign w_rs1_last = |(w_busy & w_cnt_is1 & w_sel_rs1);
  assign w_rs2_last = |(w_busy & w_cnt_is1 & w_sel_rs2);

  // A result whose count is one is on the bypass next cycle: no stall.
  assign w_raw1 = iss_rs1_use & ~w_rs1_zero & w_rs1_busy & ~w_rs1_last;
  assign w_raw2 = iss_rs2_use & ~w_rs2_zero & w_rs2_busy & ~w_rs2_last;
  assign w_waw  = iss_rd_we & w_rd_busy;

  assign iss_ready = ~(w_raw1 | w_raw2 | w_waw);
  assign fwd_rs1   = iss_rs1_use & ~w_rs1_zero & w_rs1_last;
  assign fwd_rs2   = iss_rs2_use & ~w_rs2_zero & w_rs2_last;

  assign w_fire_wr = iss_valid & iss_ready & ~flush & iss_rd_we & ~w_rd_zero;

  for (genvar gf = 0; gf < NRF; gf++) begin : g_rf
    for (genvar gr = 0; gr < NREG; gr++) begin : g_reg
      localparam int              c_idx = gf * NREG + gr;
      localparam logic [RFW-1:0]   c_rf  = RFW'(gf);
      localparam logic [ADDRW-1:0] c_reg = ADDRW'(gr);

      logic            w_wb_hit;
      logic [LATW-1:0] w_cnt;

      // Any number of write-back ports naming this entry act as one clear.
      always_comb begin
        w_wb_hit = 1'b0;
        for (int p = 0; p < NWB; p++) begin
          if (wb_valid[p] && (wb_rf[p*RFW +: RFW] == c_rf) &&
              (wb_rd[p*ADDRW +: ADDRW] == c_reg)) begin
            w_wb_hit = 1'b1;
          end
        end
      end

      assign w_sel_rs1[c_idx] = (iss_rs1_rf == c_rf) && (iss_rs1 == c_reg);
      assign w_sel_rs2[c_idx] = (iss_rs2_rf == c_rf) && (iss_rs2 == c_reg);
      assign w_sel_rd[c_idx]  = (iss_rd_rf  == c_rf) && (iss_rd  == c_reg);
      assign w_cnt_is1[c_idx] = (w_cnt == LATW'(1));

      sb_entry #(
        .LATW (LATW)
      ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .set      (w_fire_wr & w_sel_rd[c_idx]),
        .set_cnt  (iss_lat),
        .wb_clr   (w_wb_hit),
        .busy     (w_busy[c_idx]),
        .cnt      (w_cnt),
        .busy_nxt (w_busy_nxt[c_idx])
      );
    end
  end

  // Counting next-state lets the registered count line up with the entries.
  always_comb begin
    w_pop = '0;
    for (int e = 0; e < NENT; e++) begin
      w_pop = w_pop + CNTW'(w_busy_nxt[e]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_count <= '0;
      r_idle       <= 1'b1;
    end else begin
      r_busy_count <= w_pop;
      r_idle       <= (w_pop == '0);
    end
  end

  assign busy_count = r_busy_count;
  assign idle       = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_rv_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_scoreboard
//  Description : Self-checking bench for rv_scoreboard. The driver applies
//                directed vectors and queues the hand-computed outputs for
//                each cycle; a monitor on the falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_scoreboard;

  localparam int NREG   = 32;
  localparam int NRF    = 2;
  localparam int MAXLAT = 16;
  localparam int NWB    = 2;
  localparam int ADDRW  = 5;
  localparam int RFW    = 1;
  localparam int LATW   = 5;
  localparam int CNTW   = 7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 iss_valid;
  logic [ADDRW-1:0]     iss_rs1, iss_rs2, iss_rd;
  logic [RFW-1:0]       iss_rs1_rf, iss_rs2_rf, iss_rd_rf;
  logic                 iss_rs1_use, iss_rs2_use, iss_rd_we;
  logic [LATW-1:0]      iss_lat;
  logic                 iss_ready, fwd_rs1, fwd_rs2;
  logic [NWB-1:0]       wb_valid;
  logic [NWB*ADDRW-1:0] wb_rd;
  logic [NWB*RFW-1:0]   wb_rf;
  logic                 flush;
  logic [CNTW-1:0]      busy_count;
  logic                 idle;

  rv_scoreboard #(
    .NREG(NREG), .NRF(NRF), .MAXLAT(MAXLAT), .NWB(NWB), .ZERO_RF0(1)
  ) dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_rf(iss_rs1_rf), .iss_rs2_rf(iss_rs2_rf),
    .iss_rs1_use(iss_rs1_use), .iss_rs2_use(iss_rs2_use),
    .iss_rd(iss_rd), .iss_rd_rf(iss_rd_rf), .iss_rd_we(iss_rd_we),
    .iss_lat(iss_lat), .iss_ready(iss_ready),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rf(wb_rf),
    .flush(flush), .busy_count(busy_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Illegal latencies must never be driven.
  always @(posedge clk) begin
    if (iss_valid && iss_rd_we) assert (iss_lat <= LATW'(MAXLAT));
  end

  typedef struct {
    string name;
    int    cyc;
    int    ready;   // -1 = not checked
    int    fwd1;
    int    fwd2;
    int    cnt;
    int    idl;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  task automatic chk(input string name, input string field, input int act, input int expv);
    if (expv < 0) return;
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s.%s actual=%0d expected=%0d (cycle %0d)", name, field, act, expv, cyc);
    end
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        failures++;
        $display("FAIL %s stale expectation for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        chk(e.name, "iss_ready",  int'(iss_ready),  e.ready);
        chk(e.name, "fwd_rs1",    int'(fwd_rs1),    e.fwd1);
        chk(e.name, "fwd_rs2",    int'(fwd_rs2),    e.fwd2);
        chk(e.name, "busy_count", int'(busy_count), e.cnt);
        chk(e.name, "idle",       int'(idle),       e.idl);
      end
    end
  end

  task automatic expect_out(input string name, input int rdy, input int f1,
                            input int f2, input int cnt, input int idl);
    exp_t e;
    e.name = name; e.cyc = cyc; e.ready = rdy; e.fwd1 = f1; e.fwd2 = f2;
    e.cnt = cnt; e.idl = idl;
    q.push_back(e);
  endtask

  task automatic clr();
    iss_valid = 0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    iss_rs1_rf = '0; iss_rs2_rf = '0; iss_rd_rf = '0;
    iss_rs1_use = 0; iss_rs2_use = 0; iss_rd_we = 0; iss_lat = '0;
    wb_valid = '0; wb_rd = '0; wb_rf = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic dst(input int rf, input int r, input int lat);
    iss_valid = 1; iss_rd_we = 1; iss_rd_rf = RFW'(rf); iss_rd = ADDRW'(r);
    iss_lat = LATW'(lat);
  endtask

  task automatic src1(input int rf, input int r);
    iss_rs1_use = 1; iss_rs1_rf = RFW'(rf); iss_rs1 = ADDRW'(r);
  endtask

  task automatic src2(input int rf, input int r);
    iss_rs2_use = 1; iss_rs2_rf = RFW'(rf); iss_rs2 = ADDRW'(r);
  endtask

  task automatic wb(input int port, input int rf, input int r);
    wb_valid[port] = 1'b1;
    wb_rf[port*RFW +: RFW] = RFW'(rf);
    wb_rd[port*ADDRW +: ADDRW] = ADDRW'(r);
  endtask

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    clr();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    expect_out("reset", 1, 0, 0, 0, 1);

    // ---- ALU latency 1: back-to-back with forwarding ----
    step(); dst(0, 5, 1); expect_out("alu_issue", 1, 0, 0, 0, 1);
    step(); iss_valid = 1; src1(0, 5); expect_out("alu_dep", 1, 1, 0, 1, 0);
    step(); src1(0, 5); expect_out("alu_free", 1, 0, 0, 0, 1);

    // ---- FADD latency 3: two stall cycles then forward ----
    step(); dst(1, 3, 3); expect_out("fadd_issue", 1, 0, 0, 0, 1);
    step(); iss_valid = 1; src1(1, 3); expect_out("fadd_raw1_t1", 0, 0, 0, 1, 0);
    step(); iss_valid = 1; src2(1, 3); expect_out("fadd_raw2_t2", 0, 0, 0, 1, 0);
    step(); iss_valid = 1; src1(1, 3); src2(1, 3); expect_out("fadd_fwd_t3", 1, 1, 1, 1, 0);
    step(); src1(1, 3); expect_out("fadd_free", 1, 0, 0, 0, 1);

    // ---- FDIV variable latency, released by write-back port 1 ----
    step(); dst(1, 7, 0); expect_out("fdiv_issue", 1, 0, 0, 0, 1);
    for (int t = 1; t <= 9; t++) begin
      step();
      iss_valid = 1; src1(1, 7);
      if (t == 5) wb(0, 0, 7);   // int x7 is not busy: must not free f7
      if (t == 9) wb(1, 1, 7);
      expect_out($sformatf("fdiv_stall_t%0d", t), 0, 0, 0, 1, 0);
    end
    step(); iss_valid = 1; src1(1, 7); expect_out("fdiv_after_wb", 1, 0, 0, 0, 1);

    // ---- x0 never tracked, f0 is ----
    step(); dst(0, 0, 0); expect_out("x0_write", 1, 0, 0, 0, 1);
    step(); src1(0, 0); dst(1, 0, 2); expect_out("x0_read_f0_issue", 1, 0, 0, 0, 1);
    step(); iss_valid = 1; src2(1, 0); expect_out("f0_raw", 0, 0, 0, 1, 0);
    step(); iss_valid = 1; src2(1, 0); expect_out("f0_fwd", 1, 0, 1, 1, 0);
    step(); expect_out("f0_free", 1, 0, 0, 0, 1);

    // ---- WAW on f2 (fmul latency 4) ----
    step(); dst(1, 2, 4); expect_out("fmul_issue", 1, 0, 0, 0, 1);
    for (int t = 1; t <= 4; t++) begin
      step(); dst(1, 2, 1);
      expect_out($sformatf("waw_stall_t%0d", t), 0, 0, 0, 1, 0);
    end
    step(); dst(1, 2, 1); expect_out("waw_issue", 1, 0, 0, 0, 1);
    step(); expect_out("waw_new_busy", 1, 0, 0, 1, 0);

    // ---- Concurrent write-back clear and issue ----
    step(); dst(1, 5, 0); expect_out("u0_f5", 1, 0, 0, 0, 1);
    step(); dst(0, 3, 0); expect_out("u1_x3", 1, 0, 0, 1, 0);
    step(); dst(0, 4, 2); wb(0, 1, 5); expect_out("u2_wb_and_issue", 1, 0, 0, 2, 0);
    step(); src1(1, 5); expect_out("u3_f5_free", 1, 0, 0, 2, 0);
    step(); wb(0, 0, 3); wb(1, 0, 3); src1(0, 4); expect_out("u4_dual_wb", 1, 1, 0, 2, 0);
    step(); src1(0, 3); src2(0, 4); expect_out("u5_all_free", 1, 0, 0, 0, 1);

    // ---- Flush concurrent with an issue ----
    step(); dst(0, 1, 5); expect_out("fl_x1", 1, 0, 0, 0, 1);
    step(); dst(1, 4, 0); expect_out("fl_f4", 1, 0, 0, 1, 0);
    step(); flush = 1; dst(0, 9, 1); expect_out("fl_flush", 1, 0, 0, 2, 0);
    step(); iss_valid = 1; src1(0, 9); src2(0, 1); expect_out("fl_after_int", 1, 0, 0, 0, 1);
    step(); iss_valid = 1; src1(1, 4); expect_out("fl_after_fp", 1, 0, 0, 0, 1);

    // ---- Reset mid-operation ----
    step(); dst(0, 2, 3); expect_out("rst_mid_issue", 1, 0, 0, 0, 1);
    step(); reset = 1; expect_out("rst_mid_assert", -1, -1, -1, 1, 0);
    step(); reset = 0; iss_valid = 1; src1(0, 2); expect_out("rst_mid_after", 1, 0, 0, 0, 1);

    step();
    step();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations never compared", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_scoreboard.md
# rv_scoreboard

Parametrised register scoreboard for the pipelined RISC-V core. It generalises the existing fixed int/FP hazard detection to NRF register-file classes, NREG registers per class, and multi-cycle functional units of fixed or variable latency. Decode asks it whether an instruction may issue, and it reports RAW/WAW stalls and forwarding-ready sources. It sits between the controller/decode stage and the id_ex register and replaces stall generation for FP arithmetic.

## Interface
Parameters:
- NREG, 32: registers per file; ADDRW = $clog2(NREG).
- NRF, 2: register-file classes (0 = integer, 1 = FP); RFW = max(1, $clog2(NRF)).
- MAXLAT, 16: largest fixed latency; LATW = $clog2(MAXLAT+1).
- NWB, 2: variable-latency write-back ports.
- ZERO_RF0, 1: register 0 of class 0 is hard-wired and never busy.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- iss_valid  in  1  decode presents an instruction.
- iss_rs1, iss_rs2  in  ADDRW  source registers.
- iss_rs1_rf, iss_rs2_rf  in  RFW  source classes (e.g. fsw: int base, FP data).
- iss_rs1_use, iss_rs2_use  in  1  source actually read.
- iss_rd  in  ADDRW  destination; iss_rd_rf  in  RFW  destination class; iss_rd_we  in  1  writes a register.
- iss_lat  in  LATW  result latency in cycles; 0 = variable (released by write-back port).
- iss_ready  out  1  no hazard; issue fires on iss_valid & iss_ready & ~flush.
- fwd_rs1, fwd_rs2  out  1  source not in the file yet but valid on forwarding network next cycle.
- wb_valid  in  NWB  variable-latency result written.
- wb_rd  in  NWB*ADDRW, wb_rf  in  NWB*RFW  flattened write-back targets.
- flush  in  1  clear all pending entries (trap/redirect after drain).
- busy_count  out  $clog2(NRF*NREG+1)  number of busy entries.
- idle  out  1  busy_count == 0.

## Operation
- Each (class, reg) entry holds busy and cnt[LATW-1:0].
- Hazard evaluation uses registered state only.
  - RAW on a used source: busy && cnt != 1.
  - Busy with cnt == 1 is not a hazard and sets fwd_rsN = 1.
  - WAW: iss_rd_we && destination busy (any cnt).
- iss_ready = ~(RAW1 | RAW2 | WAW). It is combinational and independent of iss_valid.
- fwd_rsN is 0 when the source is unused or not busy.
- On fire with iss_rd_we, and destination not the ZERO_RF0 register, the entry gets busy=1, cnt=iss_lat.
- Every cycle, each busy entry:
  - with cnt > 1: decrement.
  - with cnt == 1: clear busy, cnt=0.
  - with cnt == 0: hold until a matching wb_valid, then clear.
- Write-back to a non-busy entry is ignored. Multiple ports hitting the same entry are equivalent to one.
- Priority in one cycle: reset > flush > issue set > countdown/write-back clear. WAW stall guarantees issue and clear never target the same entry.
- Reads of the ZERO_RF0 register never stall and never forward.
- iss_lat > MAXLAT is illegal; the bench asserts it never occurs.

## Timing
- Reset: all entries busy=0, cnt=0. busy_count=0, idle=1, iss_ready=1, fwd_rs1=fwd_rs2=0.
- Fixed latency L issued in cycle t:
  - Entry busy in cycles t+1..t+L, with cnt=L at t+1.
  - A dependent instruction may issue in cycle t+L with fwd=1.
  - Entry is free at t+L+1.
  - L=1 gives back-to-back ALU issue with forwarding.
- Variable latency: wb_valid in cycle w frees the entry at w+1. A dependent instruction issues at w+1 without forwarding and reads the write-through register file.
- flush in cycle t: all entries free at t+1. An issue in cycle t is dropped.
- Reset mid-operation behaves exactly like flush plus the reset values.
- busy_count and idle are registered; they reflect state one cycle after each change.

## Structure
- Package rv_sb_pkg:
  - class constants RF_INT=0, RF_FP=1.
  - latency constants LAT_ALU=1, LAT_LOAD=2, LAT_FADD=3, LAT_FMUL=4, LAT_VAR=0.
  - width function clog2_min1.
- Sub-module sb_entry: busy bit plus down-counter with set/clear/flush inputs. It is instantiated NRF*NREG times through generate.
- The top level owns decode of issue/write-back addresses, hazard muxes and the population count.

## Test plan
- Reset, then issue int x5 lat=1 at t=0 -> add reading x5 at t=1: iss_ready=1, fwd_rs1=1. Entry free at t=2, busy_count back to 0.
- fadd f3 lat=3 at t=0; fsub reading f3 -> iss_ready=0 at t=1,2. At t=3 iss_ready=1, fwd=1.
- fdiv f7 lat=0 at t=0, wb_valid port1 rf=1 rd=7 at t=9 -> reader stalls through t=9, issues at t=10 with fwd=0.
- Write to x0 (lat=0) -> busy_count stays 0. Reader of x0 never stalls. f0 with lat=2 does become busy.
- WAW: fmul f2 lat=4 pending, new write to f2 -> stall until f2 free. Simultaneous wb to an unrelated busy reg and a new issue to a third reg -> both applied in one cycle, busy_count exact.
- Busy int x1 (lat=5) and f4 (lat=0), flush at t=2 concurrent with an issue to x9 -> t=3: all free, x9 not busy, idle=1.
